// File: rtl/x2821_card_pkg.sv
// Shared constants and types for the card-image punch row buffer.
package x2821_card_pkg;

    localparam int unsigned COLS_DEFAULT = 80;

    // Punch step order: row 9 first, then rows 8..1, 0, 11, 12.
    localparam int unsigned ROW9_STEP  = 0;
    localparam int unsigned ROW8_STEP  = 1;
    localparam int unsigned ROW7_STEP  = 2;
    localparam int unsigned ROW6_STEP  = 3;
    localparam int unsigned ROW5_STEP  = 4;
    localparam int unsigned ROW4_STEP  = 5;
    localparam int unsigned ROW3_STEP  = 6;
    localparam int unsigned ROW2_STEP  = 7;
    localparam int unsigned ROW1_STEP  = 8;
    localparam int unsigned ROW0_STEP  = 9;
    localparam int unsigned ROW11_STEP = 10;
    localparam int unsigned ROW12_STEP = 11;

    // Bit positions inside a 12-bit column hole pattern.
    localparam int unsigned HOLE_12 = 11;
    localparam int unsigned HOLE_11 = 10;
    localparam int unsigned HOLE_0  = 9;
    localparam int unsigned HOLE_1  = 8;
    localparam int unsigned HOLE_2  = 7;
    localparam int unsigned HOLE_3  = 6;
    localparam int unsigned HOLE_4  = 5;
    localparam int unsigned HOLE_5  = 4;
    localparam int unsigned HOLE_6  = 3;
    localparam int unsigned HOLE_7  = 2;
    localparam int unsigned HOLE_8  = 1;
    localparam int unsigned HOLE_9  = 0;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PUNCH = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/card_row_select.sv
// Gathers one hole row across all columns of the stored card image.
module card_row_select
    import x2821_card_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT
) (
    input  logic [COLS-1:0][11:0] card_i,
    input  logic [3:0]            row_i,
    output logic [COLS-1:0]       bits_o
);

    // Step k of the punch sequence is hole bit k of every column.
    always_comb begin
        bits_o = '0;
        if (row_i <= 4'(ROW12_STEP)) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                bits_o[c] = card_i[c][row_i];
            end
        end
    end

endmodule

// File: rtl/punch_row_buffer.sv
// Column-serial card loader that replays the card as 12 row images in punch order.
module punch_row_buffer
    import x2821_card_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned CW   = 7
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [11:0]     i_holes,
    input  logic            i_col_valid,
    output logic            o_col_ready,
    input  logic            i_card_end,
    output logic [CW-1:0]   o_col_count,
    output logic            o_row_valid,
    output logic [3:0]      o_row_num,
    output logic [COLS-1:0] o_row_bits,
    input  logic            i_row_ready,
    input  logic            i_abort,
    output logic            o_card_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [3:0]    ROW_LAST = 4'(ROW12_STEP);

    state_e                 state_q;
    logic [COLS-1:0][11:0]  card_q;
    logic [CW-1:0]          col_q;
    logic [3:0]             row_q;

    // Card FSM: load columns, step rows under punch backpressure, then clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_abort) begin
            state_q <= LOAD;
            card_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (i_col_valid) begin
                        card_q[col_q] <= i_holes;
                        col_q         <= col_q + CW'(1);
                        if (col_q == COL_LAST) begin
                            state_q <= PUNCH;
                        end
                    end
                    if (i_card_end) begin
                        state_q <= PUNCH;
                    end
                end
                PUNCH: begin
                    if (i_row_ready) begin
                        if (row_q == ROW_LAST) begin
                            state_q <= DONE;
                        end else begin
                            row_q <= row_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= LOAD;
                    card_q  <= '0;
                    col_q   <= '0;
                    row_q   <= '0;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Handshake and status decode directly from the held state.
    assign o_col_ready = (state_q == LOAD);
    assign o_row_valid = (state_q == PUNCH);
    assign o_card_done = (state_q == DONE);
    assign o_col_count = col_q;
    assign o_row_num   = row_q;

    card_row_select #(
        .COLS (COLS)
    ) u_row_select (
        .card_i (card_q),
        .row_i  (row_q),
        .bits_o (o_row_bits)
    );

endmodule

// File: tb/tb_punch_row_buffer.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a card model.
module tb_punch_row_buffer;

    localparam int unsigned COLS = 80;
    localparam int unsigned CW   = 7;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic [11:0]     i_holes = '0;
    logic            i_col_valid = 1'b0;
    logic            o_col_ready;
    logic            i_card_end = 1'b0;
    logic [CW-1:0]   o_col_count;
    logic            o_row_valid;
    logic [3:0]      o_row_num;
    logic [COLS-1:0] o_row_bits;
    logic            i_row_ready = 1'b0;
    logic            i_abort = 1'b0;
    logic            o_card_done;

    punch_row_buffer #(.COLS(COLS), .CW(CW)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_holes     (i_holes),
        .i_col_valid (i_col_valid),
        .o_col_ready (o_col_ready),
        .i_card_end  (i_card_end),
        .o_col_count (o_col_count),
        .o_row_valid (o_row_valid),
        .o_row_num   (o_row_num),
        .o_row_bits  (o_row_bits),
        .i_row_ready (i_row_ready),
        .i_abort     (i_abort),
        .o_card_done (o_card_done)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_on = 1'b0;

    // Card model: 0 = loading, 1 = punching, 2 = done cycle.
    int          m_phase = 0;
    logic [11:0] m_cols [COLS];
    int          m_ncol = 0;
    int          m_step = 0;

    task automatic model_clear();
        m_phase = 0;
        m_ncol  = 0;
        m_step  = 0;
        for (int c = 0; c < int'(COLS); c++) m_cols[c] = '0;
    endtask

    function automatic logic [COLS-1:0] model_row(input int step);
        logic [COLS-1:0] r;
        r = '0;
        for (int c = 0; c < int'(COLS); c++) r[c] = m_cols[c][step];
        return r;
    endfunction

    // Advance the model on every rising edge from the stable driven inputs.
    initial begin
        model_clear();
        forever begin
            @(posedge i_clk);
            if (!i_reset || i_abort) begin
                model_clear();
            end else if (m_phase == 0) begin
                if (i_col_valid) begin
                    m_cols[m_ncol] = i_holes;
                    m_ncol++;
                    if (m_ncol == int'(COLS)) m_phase = 1;
                end
                if (i_card_end) m_phase = 1;
            end else if (m_phase == 1) begin
                if (i_row_ready) begin
                    if (m_step == 11) m_phase = 2;
                    else m_step++;
                end
            end else begin
                model_clear();
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model on every falling edge.
    always @(negedge i_clk) begin
        if (model_on) begin
            chk("col_ready", 128'(o_col_ready), 128'(m_phase == 0));
            chk("row_valid", 128'(o_row_valid), 128'(m_phase == 1));
            chk("card_done", 128'(o_card_done), 128'(m_phase == 2));
            chk("col_count", 128'(o_col_count), 128'(m_ncol));
            if (m_phase == 1) begin
                chk("row_num",  128'(o_row_num),  128'(m_step));
                chk("row_bits", 128'(o_row_bits), 128'(model_row(m_step)));
            end
        end
    end

    // One clock of stimulus; returns #1 after the edge so outputs are settled.
    task automatic cyc(input logic v, input logic [11:0] h, input logic ce,
                       input logic rr, input logic ab, input logic rst_n);
        i_col_valid = v;
        i_holes     = h;
        i_card_end  = ce;
        i_row_ready = rr;
        i_abort     = ab;
        i_reset     = rst_n;
        @(posedge i_clk);
        #1;
        i_col_valid = 1'b0;
        i_card_end  = 1'b0;
        i_abort     = 1'b0;
        i_reset     = 1'b1;
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 12'h000, 1'b0, rr, 1'b0, 1'b1);
    endtask

    // Drain the card with i_row_ready high until the model is loading again.
    task automatic drain();
        int n;
        n = 0;
        while (m_phase != 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        if (m_phase != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got phase %0d expected 0", m_phase);
        end
    endtask

    initial begin
        logic [COLS-1:0] pat;
        logic [COLS-1:0] held;
        int dones;

        // Reset
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        model_on = 1'b1;
        chk("rst_col_ready", 128'(o_col_ready), 128'(1));
        chk("rst_col_count", 128'(o_col_count), 128'(0));
        chk("rst_row_valid", 128'(o_row_valid), 128'(0));
        chk("rst_card_done", 128'(o_card_done), 128'(0));

        // Short card of three 'A' columns
        for (int i = 0; i < 3; i++) cyc(1'b1, 12'h900, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk("short_valid", 128'(o_row_valid), 128'(1));
            chk("short_num", 128'(o_row_num), 128'(k));
            chk("short_bits", 128'(o_row_bits), (k == 8 || k == 11) ? 128'h7 : 128'h0);
            chk("short_count", 128'(o_col_count), 128'(3));
            idle(1'b1);
        end
        chk("short_done", 128'(o_card_done), 128'(1));
        chk("short_done_rv", 128'(o_row_valid), 128'(0));
        idle(1'b1);
        chk("short_done_end", 128'(o_card_done), 128'(0));
        chk("short_reload", 128'(o_col_ready), 128'(1));

        // Full card, then one extra column that must be refused
        for (int c = 0; c < int'(COLS); c++) begin
            cyc(1'b1, 12'h001 << (c % 12), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("full_ready_low", 128'(o_col_ready), 128'(0));
        chk("full_count", 128'(o_col_count), 128'(80));
        cyc(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("full_81st_count", 128'(o_col_count), 128'(80));
        for (int k = 0; k < 12; k++) begin
            pat = '0;
            for (int c = 0; c < int'(COLS); c++) if (c % 12 == k) pat[c] = 1'b1;
            chk("full_num", 128'(o_row_num), 128'(k));
            chk("full_bits", 128'(o_row_bits), 128'(pat));
            idle(1'b1);
        end
        idle(1'b1);

        // Row backpressure at step 4
        cyc(1'b1, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        chk("bp_step4", 128'(o_row_num), 128'(4));
        chk("bp_bits4", 128'(o_row_bits), 128'h1);
        held = o_row_bits;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("bp_hold_num", 128'(o_row_num), 128'(4));
            chk("bp_hold_bits", 128'(o_row_bits), 128'(held));
        end
        idle(1'b1);
        chk("bp_step5", 128'(o_row_num), 128'(5));
        drain();

        // Abort at step 6 after a dense card
        for (int i = 0; i < 12; i++) cyc(1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) idle(1'b1);
        chk("ab_step6", 128'(o_row_num), 128'(6));
        cyc(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ab_row_valid", 128'(o_row_valid), 128'(0));
        chk("ab_col_count", 128'(o_col_count), 128'(0));
        chk("ab_ready", 128'(o_col_ready), 128'(1));
        chk("ab_no_done", 128'(o_card_done), 128'(0));
        cyc(1'b1, 12'h200, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ab_no_done2", 128'(o_card_done), 128'(0));
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk("ab_reload_bits", 128'(o_row_bits), (k == 9) ? 128'h1 : 128'h0);
            idle(1'b1);
        end
        idle(1'b1);

        // Reset in the middle of loading
        for (int i = 0; i < 10; i++) cyc(1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rml_count", 128'(o_col_count), 128'(0));
        chk("rml_ready", 128'(o_col_ready), 128'(1));
        cyc(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 12) chk("rml_blank", 128'(o_row_bits), 128'h0);
            if (o_card_done) dones++;
            idle(1'b1);
        end
        chk("rml_one_done", 128'(dones), 128'(1));

        // Column and card end on the same edge
        cyc(1'b1, 12'h800, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sim_count", 128'(o_col_count), 128'(1));
        chk("sim_valid", 128'(o_row_valid), 128'(1));
        for (int k = 0; k < 12; k++) begin
            chk("sim_bits", 128'(o_row_bits), (k == 11) ? 128'h1 : 128'h0);
            idle(1'b1);
        end
        idle(1'b1);

        // Randomized traffic; the negedge compare process checks every cycle
        for (int i = 0; i < 4000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                12'($urandom),
                1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 199) == 0),
                1'($urandom_range(0, 499) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/punch_row_buffer.md
Name: punch_row_buffer

Overview:
Card-image buffer between the EBCDIC-to-holes converter and the punch-magnet driver. It collects up to COLS 12-bit column hole patterns for one card, then replays the card as 12 row images in punch order: row 9 first, then rows 8 through 1, 0, 11 and 12. Each row image is a COLS-bit vector with one bit per column. The block isolates the column-serial converter from the row-serial punch station timing.

Parameters:
COLS, 80, columns per card
CW, 7, column counter width; must satisfy 2**CW > COLS

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_reset  input  1  synchronous reset, active-low (0 = reset)
i_holes  input  12  column pattern {12,11,0,1,2,3,4,5,6,7,8,9}; bit11 = row 12, bit0 = row 9
i_col_valid  input  1  i_holes valid this cycle
o_col_ready  output  1  buffer accepting columns
i_card_end  input  1  end-of-card strobe; honoured only while o_col_ready=1
o_col_count  output  CW  columns accepted for the current card
o_row_valid  output  1  o_row_bits / o_row_num valid
o_row_num  output  4  punch step 0..11; step k carries hole bit k (0 = row 9, 11 = row 12)
o_row_bits  output  COLS  bit c = hole of column c in the current row
i_row_ready  input  1  punch driver consumed the row
i_abort  input  1  discard the card and return to LOAD
o_card_done  output  1  one-cycle pulse after step 11 is accepted

Behaviour:
- States: LOAD, PUNCH, DONE.
- Reset (i_reset=0 at an edge) has priority over everything. After reset:
  - state LOAD; all buffer bits 0; column counter 0; row counter 0
  - o_col_ready=1, o_row_valid=0, o_card_done=0, o_col_count=0
- LOAD:
  - o_col_ready=1, o_row_valid=0.
  - A column is accepted when i_col_valid=1. i_holes is written to buf[col] and col increments in the same edge.
  - When the accept makes col reach COLS, the next state is PUNCH.
  - i_card_end=1 moves to PUNCH. If it coincides with i_col_valid, the column is written first.
  - i_card_end with col=0 still moves to PUNCH and produces a blank card (12 all-zero rows).
  - Unwritten columns stay 0, so a short card is padded with blanks.
- PUNCH:
  - o_col_ready=0. i_col_valid and i_card_end are ignored; no write occurs and col holds.
  - o_row_valid=1, o_row_num=row, o_row_bits[c]=buf[c][row].
  - Outputs hold stable until i_row_ready=1. On the ready edge, row increments.
  - Step 11 accepted with i_row_ready moves to DONE.
  - Throughput: one row per cycle when i_row_ready is held high. The first row is valid in the cycle after the last column is accepted (or after i_card_end).
- DONE (one cycle):
  - o_card_done=1, o_row_valid=0, o_col_ready=0.
  - All buffer bits, col and row are cleared.
  - Next state is LOAD.
- i_abort=1 in any state (lower priority than reset) behaves as DONE without the o_card_done pulse: buffer, col and row are cleared, next state LOAD, and no column is written that cycle.
- o_col_count shows col; it is held through PUNCH and cleared in DONE/abort.
- No other outputs are registered beyond the state, counters and buffer. o_row_bits is a combinational gather of buf by row.

Decomposition:
- Package x2821_card_pkg holds:
  - COLS_DEFAULT = 80
  - row step constants: ROW9_STEP=0 … ROW0_STEP=9, ROW11_STEP=10, ROW12_STEP=11
  - hole bit indices HOLE_12=11, HOLE_11=10, HOLE_0=9 … HOLE_9=0
  - state enum {LOAD, PUNCH, DONE}
- One sub-module, card_row_select (COLS×12 storage in, 4-bit row in, COLS-bit row vector out, purely combinational). The FSM, counters and storage stay in punch_row_buffer.

Test Plan:
- Short card: after reset, columns 0x900, 0x900, 0x900 (EBCDIC C1 'A' = 12-1), then i_card_end; i_row_ready held 1.
  - Required: steps 0..11 on consecutive cycles.
  - Step 8 (row 1) and step 11 (row 12) have o_row_bits[2:0]=3'b111 with all other bits 0; every other step is all-zero.
  - o_card_done pulses one cycle after step 11; o_col_count=3 during PUNCH.
- Full card:
  - Stimulus: 80 columns, column c = 12'h001 << (c%12), with no i_card_end.
  - Required: o_col_ready drops after the 80th accept. The 81st i_col_valid is not accepted and col stays 80.
  - Required: step k shows bit c set exactly when c%12==k.
- Row backpressure: i_row_ready low for 5 cycles at step 4.
  - Required: o_row_num=4 and o_row_bits stable for all 5 cycles.
  - Required: step 5 appears the cycle after i_row_ready rises.
- Abort: i_abort at step 6.
  - Required: next cycle state LOAD, o_row_valid=0, o_col_count=0, no o_card_done.
  - Then load column 0x200 and i_card_end: only step 9 (row 0) has bit0=1, proving the buffer was cleared.
- Reset mid-load:
  - Stimulus: load 10 columns, then drive i_reset=0 for 1 cycle.
  - Required: o_col_count=0, o_col_ready=1.
  - Then i_card_end alone: a blank card with 12 zero rows and one o_card_done.
- Simultaneous column and end: i_col_valid=1 and i_card_end=1 on column 0x800.
  - Required: column 0 is written; o_col_count=1; step 11 has bit0=1.
